// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_pkg
// Description : Shared definitions for the multicycle sequencer. Holds the
//               opcode values recognised by the decoder, the 3-bit state
//               encoding, the fault codes, and an opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_sequencer_pkg;

  // Opcodes. These are the same nine values the decoder recognises.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // State encoding. Value 6 is unused.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd7
  } state_t;

  // Fault codes reported on the fault output.
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM_TO = 2'b10;
  localparam logic [1:0] FAULT_DMEM_TO = 2'b11;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_wait_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_wait_watchdog
// Description : Wait-state counter shared by the FETCH and MEMORY waits.
//               o_expired flags the cycle that would be the TIMEOUT_CYCLES-th
//               consecutive wait cycle, so the FSM can fault in that cycle.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_clear      - zero the count (takes priority over i_enable)
//               i_enable     - count one more wait cycle
//               o_expired    - current wait cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer_wait_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TIMEOUT_BITS-1:0] c_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_BITS-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The count holds the number of wait cycles already spent, so the current
  // cycle is the TIMEOUT_CYCLES-th one when the count equals TIMEOUT_CYCLES-1.
  assign o_expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Control FSM sequencing the single-datapath core through
//               IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT. Gates the
//               decoder enables so each fires once per instruction, owns the
//               imem/dmem handshakes, a wait watchdog and a retire counter.
// Ports       : clock, reset           - clock, synchronous active-high reset
//               start, halt_req        - run control
//               opcode                 - instruction[6:0] from the IR
//               imem_valid, dmem_ready - memory handshakes
//               imem_req, ir_wEn, dmem_req, mem_wEn_gate, rf_wEn_gate,
//               pc_wEn                 - per-phase strobes / gates
//               busy, halted, fault, retired - status
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8,
  parameter int RETIRE_BITS    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic [6:0]             opcode,
  input  logic                   imem_valid,
  input  logic                   dmem_ready,
  output logic                   imem_req,
  output logic                   ir_wEn,
  output logic                   dmem_req,
  output logic                   mem_wEn_gate,
  output logic                   rf_wEn_gate,
  output logic                   pc_wEn,
  output logic                   busy,
  output logic                   halted,
  output logic [1:0]             fault,
  output logic [RETIRE_BITS-1:0] retired
);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_fault;
  logic [RETIRE_BITS-1:0] r_retired;

  logic       w_imem_req, w_ir_wEn, w_dmem_req, w_mem_wEn, w_rf_wEn, w_pc_wEn;
  logic       w_retire, w_fault_set, w_wd_en, w_wd_clear, w_wd_expired;
  logic [1:0] w_fault_code;
  logic       w_is_load, w_is_store;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_fault   <= FAULT_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_fault_set) r_fault <= w_fault_code;
      if (w_retire)    r_retired <= r_retired + RETIRE_BITS'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_imem_req   = 1'b0;
    w_ir_wEn     = 1'b0;
    w_dmem_req   = 1'b0;
    w_mem_wEn    = 1'b0;
    w_rf_wEn     = 1'b0;
    w_pc_wEn     = 1'b0;
    w_retire     = 1'b0;
    w_wd_en      = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_code = FAULT_NONE;

    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_valid) begin
          // A valid word in the last allowed cycle still wins over timeout.
          w_ir_wEn = 1'b1;
          w_next   = ST_DECODE;
        end else begin
          w_wd_en = 1'b1;
          if (w_wd_expired) begin
            w_next       = ST_HALT;
            w_fault_set  = 1'b1;
            w_fault_code = FAULT_IMEM_TO;
          end
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          w_next = ST_EXECUTE;
        end else begin
          w_next       = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        if (w_is_load || w_is_store) begin
          w_next = ST_MEMORY;
        end else if (opcode == OP_BRANCH) begin
          w_pc_wEn = 1'b1;
          w_retire = 1'b1;
          w_next   = halt_req ? ST_IDLE : ST_FETCH;
        end else begin
          w_next = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        w_dmem_req = 1'b1;
        if (dmem_ready) begin
          if (w_is_load) begin
            w_next = ST_WRITEBACK;
          end else begin
            // Only loads and stores reach MEMORY, so this is the store commit.
            w_mem_wEn = 1'b1;
            w_pc_wEn  = 1'b1;
            w_retire  = 1'b1;
            w_next    = halt_req ? ST_IDLE : ST_FETCH;
          end
        end else begin
          w_wd_en = 1'b1;
          if (w_wd_expired) begin
            w_next       = ST_HALT;
            w_fault_set  = 1'b1;
            w_fault_code = FAULT_DMEM_TO;
          end
        end
      end
      ST_WRITEBACK: begin
        w_rf_wEn = 1'b1;
        w_pc_wEn = 1'b1;
        w_retire = 1'b1;
        w_next   = halt_req ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Only one wait state is ever active, so one watchdog serves both. It is
  // cleared whenever no wait cycle is being counted, including on handshake.
  assign w_wd_clear = ~w_wd_en;

  multicycle_sequencer_wait_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_BITS   (TIMEOUT_BITS)
  ) u_watchdog (
    .clk       (clock),
    .rst       (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_expired (w_wd_expired)
  );

  // The state register still holds the aborted state during the reset cycle,
  // so every strobe is masked by reset to keep that cycle side-effect free.
  assign imem_req     = w_imem_req & ~reset;
  assign ir_wEn       = w_ir_wEn   & ~reset;
  assign dmem_req     = w_dmem_req & ~reset;
  assign mem_wEn_gate = w_mem_wEn  & ~reset;
  assign rf_wEn_gate  = w_rf_wEn   & ~reset;
  assign pc_wEn       = w_pc_wEn   & ~reset;

  assign busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted  = (r_state == ST_HALT);
  assign fault   = r_fault;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer with a
//               short watchdog (TIMEOUT_CYCLES=4). Each step drives inputs,
//               checks the packed strobe/status vector against a hand-derived
//               value, then advances one clock.
//               Packed vector: {imem_req, ir_wEn, dmem_req, mem_wEn_gate,
//                               rf_wEn_gate, pc_wEn, busy, halted}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

  localparam logic [6:0] c_OP_ALU    = 7'b0110011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_BAD    = 7'b0000000;

  // Expected packed vectors per phase.
  localparam logic [7:0] c_IDLE    = 8'b0000_0000;
  localparam logic [7:0] c_F_VAL   = 8'b1100_0010;
  localparam logic [7:0] c_F_WAIT  = 8'b1000_0010;
  localparam logic [7:0] c_DEC     = 8'b0000_0010;
  localparam logic [7:0] c_EXE     = 8'b0000_0010;
  localparam logic [7:0] c_EXE_BR  = 8'b0000_0110;
  localparam logic [7:0] c_MEM     = 8'b0010_0010;
  localparam logic [7:0] c_MEM_ST  = 8'b0011_0110;
  localparam logic [7:0] c_WB      = 8'b0000_1110;
  localparam logic [7:0] c_HALT    = 8'b0000_0001;
  localparam logic [7:0] c_RST_MEM = 8'b0000_0010;

  logic        clock = 1'b0;
  logic        reset, start, halt_req, imem_valid, dmem_ready;
  logic [6:0]  opcode;
  logic        imem_req, ir_wEn, dmem_req, mem_wEn_gate, rf_wEn_gate, pc_wEn;
  logic        busy, halted;
  logic [1:0]  fault;
  logic [31:0] retired;
  logic [7:0]  w_outs;

  int errors = 0;
  int checks = 0;

  multicycle_sequencer #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_BITS   (8),
    .RETIRE_BITS    (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .halt_req     (halt_req),
    .opcode       (opcode),
    .imem_valid   (imem_valid),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_wEn       (ir_wEn),
    .dmem_req     (dmem_req),
    .mem_wEn_gate (mem_wEn_gate),
    .rf_wEn_gate  (rf_wEn_gate),
    .pc_wEn       (pc_wEn),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  always #5 clock = ~clock;

  assign w_outs = {imem_req, ir_wEn, dmem_req, mem_wEn_gate,
                   rf_wEn_gate, pc_wEn, busy, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs were set just after a rising edge; let them settle, check the
  // current-cycle outputs, then move to 1ns past the next rising edge.
  task automatic step(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, w_outs}, {24'd0, exp});
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0;
    imem_valid = 1'b0; dmem_ready = 1'b0; opcode = c_OP_ALU;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_fault", {30'd0, fault}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    step("rst_idle", c_IDLE);

    // ALU: F(ir_wEn) D E WB(rf+pc), halt_req at WB returns to IDLE
    opcode = c_OP_ALU; imem_valid = 1'b1; start = 1'b1;
    step("alu_c0_idle", c_IDLE);
    start = 1'b0;
    step("alu_c1_fetch", c_F_VAL);
    step("alu_c2_dec", c_DEC);
    step("alu_c3_exe", c_EXE);
    halt_req = 1'b1;
    step("alu_c4_wb", c_WB);
    halt_req = 1'b0;
    chk("alu_retired", retired, 32'd1);
    step("alu_back_idle", c_IDLE);

    // LOAD with 3 not-ready cycles; halt_req raised during the wait
    opcode = c_OP_LOAD; start = 1'b1; dmem_ready = 1'b0;
    step("ld_idle", c_IDLE);
    start = 1'b0;
    step("ld_fetch", c_F_VAL);
    step("ld_dec", c_DEC);
    step("ld_exe", c_EXE);
    step("ld_mem_w1", c_MEM);
    halt_req = 1'b1;
    step("ld_mem_w2", c_MEM);
    step("ld_mem_w3", c_MEM);
    dmem_ready = 1'b1;
    step("ld_mem_rdy", c_MEM);
    dmem_ready = 1'b0;
    step("ld_wb", c_WB);
    halt_req = 1'b0;
    chk("ld_retired", retired, 32'd2);
    step("ld_halt_idle", c_IDLE);

    // STORE then BRANCH back-to-back
    opcode = c_OP_STORE; start = 1'b1; dmem_ready = 1'b1;
    step("st_idle", c_IDLE);
    start = 1'b0;
    step("st_fetch", c_F_VAL);
    step("st_dec", c_DEC);
    step("st_exe", c_EXE);
    step("st_mem", c_MEM_ST);
    opcode = c_OP_BRANCH;
    step("br_fetch", c_F_VAL);
    step("br_dec", c_DEC);
    halt_req = 1'b1;
    step("br_exe", c_EXE_BR);
    halt_req = 1'b0;
    chk("stbr_retired", retired, 32'd4);
    step("stbr_idle", c_IDLE);

    // Illegal opcode: HALT, fault 01, sticky, start/halt_req ignored
    opcode = c_OP_BAD; start = 1'b1; dmem_ready = 1'b0;
    step("ill_idle", c_IDLE);
    start = 1'b0;
    step("ill_fetch", c_F_VAL);
    step("ill_dec", c_DEC);
    chk("ill_fault", {30'd0, fault}, 32'd1);
    start = 1'b1; halt_req = 1'b1;
    step("ill_halt1", c_HALT);
    start = 1'b0; halt_req = 1'b0;
    step("ill_halt2", c_HALT);
    chk("ill_retired", retired, 32'd4);
    chk("ill_fault_held", {30'd0, fault}, 32'd1);
    do_reset();
    chk("ill_rst_fault", {30'd0, fault}, 32'd0);
    chk("ill_rst_retired", retired, 32'd0);
    step("ill_rst_idle", c_IDLE);

    // Fetch timeout: 4 waiting FETCH cycles then HALT with fault 10
    opcode = c_OP_BRANCH; imem_valid = 1'b0; start = 1'b1;
    step("ito_idle", c_IDLE);
    start = 1'b0;
    step("ito_f1", c_F_WAIT);
    step("ito_f2", c_F_WAIT);
    step("ito_f3", c_F_WAIT);
    step("ito_f4", c_F_WAIT);
    step("ito_halt", c_HALT);
    chk("ito_fault", {30'd0, fault}, 32'd2);
    do_reset();

    // Valid on the 4th FETCH cycle wins over the timeout
    start = 1'b1;
    step("ivw_idle", c_IDLE);
    start = 1'b0;
    step("ivw_f1", c_F_WAIT);
    step("ivw_f2", c_F_WAIT);
    step("ivw_f3", c_F_WAIT);
    imem_valid = 1'b1;
    step("ivw_f4", c_F_VAL);
    step("ivw_dec", c_DEC);
    chk("ivw_fault", {30'd0, fault}, 32'd0);
    halt_req = 1'b1;
    step("ivw_exe_br", c_EXE_BR);
    halt_req = 1'b0;
    chk("ivw_retired", retired, 32'd1);

    // Data timeout: LOAD never ready, 4 MEMORY cycles then HALT fault 11
    opcode = c_OP_LOAD; start = 1'b1; dmem_ready = 1'b0;
    step("dto_idle", c_IDLE);
    start = 1'b0;
    step("dto_fetch", c_F_VAL);
    step("dto_dec", c_DEC);
    step("dto_exe", c_EXE);
    step("dto_m1", c_MEM);
    step("dto_m2", c_MEM);
    step("dto_m3", c_MEM);
    step("dto_m4", c_MEM);
    step("dto_halt", c_HALT);
    chk("dto_fault", {30'd0, fault}, 32'd3);
    chk("dto_retired", retired, 32'd1);
    do_reset();

    // Reset during a STORE's ready MEMORY cycle: no gate fires
    opcode = c_OP_STORE; start = 1'b1;
    step("rm_idle", c_IDLE);
    start = 1'b0;
    step("rm_fetch", c_F_VAL);
    step("rm_dec", c_DEC);
    step("rm_exe", c_EXE);
    dmem_ready = 1'b1; reset = 1'b1;
    step("rm_mem_in_reset", c_RST_MEM);
    reset = 1'b0; dmem_ready = 1'b0;
    chk("rm_retired", retired, 32'd0);
    chk("rm_fault", {30'd0, fault}, 32'd0);
    step("rm_idle_after", c_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
